bus_dev_port: RTL and testbench
===============================

# bus_dev_port

Synthesizable device-side endpoint for the arbitrated bus driven by `bs_gntrt_n_rbtr`. It is the responder end of the pndng/pop/D_pop and push/D_push handshake, and replaces the behavioural Driver_Monitor with RTL. The TX queue holds packets the device wants to send. The bus pops them through `D_pop`. The RX queue captures packets the bus pushes through `D_push` and filters them by destination id. One instance is used per bus driver slot.

## Interface
Parameters:
- `pckg_sz`, 16: packet width. Bits `[pckg_sz-1:pckg_sz-8]` are the destination id; the rest is payload. Must be ≥ 9.
- `depth`, 8: entries per queue. Power of two, ≥ 2.
- `my_id`, 0: this port's 8-bit id.
- `broadcast`, 8'hFF: broadcast id.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `pndng`  out  1  TX queue not empty.
- `pop`  in  1  the bus consumes the TX head this cycle.
- `D_pop`  out  pckg_sz  TX head, first-word fall-through.
- `push`  in  1  the bus delivers `D_push` this cycle.
- `D_push`  in  pckg_sz  incoming packet.
- `wr_en`  in  1  device enqueues `wr_data`.
- `wr_data`  in  pckg_sz  outgoing packet.
- `tx_full`  out  1  TX queue full.
- `rd_en`  in  1  device dequeues the RX head.
- `rd_data`  out  pckg_sz  RX head, first-word fall-through.
- `rx_empty`  out  1  RX queue empty.
- `rx_cnt`  out  $clog2(depth)+1  RX occupancy.
- `drop_cnt`  out  8  packets dropped because RX was full or the id mismatched. Saturates at 255.
- `err`  out  3  sticky flags: [0] write while TX full, [1] pop while TX empty, [2] read while RX empty.

## Operation
- TX queue:
  - `wr_en` with `!tx_full` writes `wr_data` at the write pointer.
  - `pop` with `pndng` advances the read pointer.
  - `D_pop` always shows `mem[rd_ptr]`. Its value is don't-care when empty.
- Full TX queue with `wr_en` and `pop` in the same cycle: both operations take effect and the count stays at `depth`. Full with `wr_en` and no `pop`: the write is ignored and `err[0]` is set.
- Empty TX queue with `pop`: ignored, pointers unchanged, `err[1]` is set.
- RX acceptance: a packet is accepted when `push` is high and its id equals `my_id` or `broadcast`.
  - Accepted with room, or accepted while full but with `rd_en` in the same cycle: enqueued.
  - Accepted while full without `rd_en`: dropped, `drop_cnt` increments.
  - Id mismatch: dropped, `drop_cnt` increments.
- RX empty with `rd_en`: ignored and `err[2]` is set. This holds even if `push` is high in the same cycle; the pushed packet still lands.
- Pointers are `$clog2(depth)` bits and wrap modulo `depth`. Occupancy is `$clog2(depth)+1` bits. Full means `count==depth`; empty means `count==0`.
- The `err` flags clear only on `reset`.

## Timing
- Reset values:
  - `pndng`=0, `tx_full`=0, `rx_empty`=1, `rx_cnt`=0, `drop_cnt`=0, `err`=0.
  - `D_pop` and `rd_data` are don't-care; memory contents are not cleared.
- Write-to-visible latency is 1 cycle: `wr_en` at edge N gives `pndng`=1 and `D_pop`=data after edge N. The same applies to `push` → `!rx_empty`.
- `pop` at edge N: `D_pop` shows the next entry after edge N, and `pndng` drops after edge N if that was the last entry.
- Flags are registered-count derived: `pndng`, `tx_full` and `rx_empty` are combinational from registered counts. There is no combinational path from `pop`/`push` to any output.
- `reset` asserted mid-transfer:
  - Both queues empty immediately, asynchronously.
  - Any `pop` or `push` in progress is lost.
  - `pndng` falls without waiting for a clock edge.

## Structure
- Package `bus_dev_pkg`:
  - `ID_W`=8.
  - `id_t` typedef.
  - function `pkt_id(pkt)` returning the top 8 bits.
  - `err_e` bit-index enum: `ERR_TX_OVF`, `ERR_TX_UDF`, `ERR_RX_UDF`.
- Sub-module `fifo_fwft`, parameterized by `width` and `depth`, with ports `push`, `pop`, `din`, `dout`, `full`, `empty`, `count`. It is instantiated twice (TX, RX). Id filtering, drop counting and error flags live in the top module.

## Test plan
- Reset then `wr_en` with `16'h0233`, `16'hFF55`: `pndng`=1 and `D_pop`=0233. After one `pop`, `D_pop`=FF55. After a second `pop`, `pndng`=0.
- With `my_id`=3: push `16'h03AA`, `16'hFF01`, `16'h0477` → `rx_cnt`=2 and `drop_cnt`=1. Reads return 03AA then FF01.
- Fill TX with 8 writes → `tx_full`=1. A 9th write alone sets `err[0]` and is not stored. A write plus `pop` in the same cycle keeps `tx_full`=1; the popped head is entry 0 and the new data sits at entry 8.
- `pop` and `rd_en` on empty queues → `err`=3'b110 and pointers unchanged. `rd_en` plus `push 16'h0310` on empty RX → `err[2]`=1, `rx_cnt`=1, `rd_data`=0310.
- Do 20 write/pop pairs through depth 8: data comes out in order across the pointer wrap. Then push 300 mismatched packets: `drop_cnt` saturates at 255.
- Load TX with 3 packets, assert `reset` between edges: `pndng`=0 before the next edge. After release, new writes begin at entry 0.

Source files
------------

// File: rtl/bus_dev_pkg.sv
// Shared types for the bus device port: packet id extraction and sticky error bit positions.
package bus_dev_pkg;

   localparam int ID_W      = 8;
   localparam int PKT_MAX_W = 256;

   typedef logic [ID_W-1:0] id_t;

   typedef enum logic [1:0] {
      ERR_TX_OVF = 2'd0,
      ERR_TX_UDF = 2'd1,
      ERR_RX_UDF = 2'd2
   } err_e;

   // Packet arrives zero-extended to PKT_MAX_W; the id is the top ID_W bits of the real width.
   function automatic id_t pkt_id(input logic [PKT_MAX_W-1:0] pkt, input int unsigned pkt_w);
      return id_t'(pkt >> (pkt_w - ID_W));
   endfunction

endpackage

// File: rtl/fifo_fwft.sv
// First-word-fall-through FIFO; a push into a full queue succeeds only when a pop frees a slot in the same cycle.
module fifo_fwft #(
   parameter int width = 16,
   parameter int depth = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [width-1:0]         din,
   output logic [width-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(depth):0]   count
);

   localparam int PW = $clog2(depth);
   localparam int CW = PW + 1;

   logic [width-1:0] mem_q [depth];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CW'(depth));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      // NOTE: every output of this block is defaulted first so no path leaves a latch behind.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: non-blocking assignments keep every register sampling pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage has no reset; the count alone decides what is valid, so memories map to plain RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/bus_dev_port.sv
// Device-side bus endpoint: TX queue drained by the bus, RX queue filled by the bus with id filtering.
module bus_dev_port
   import bus_dev_pkg::*;
#(
   parameter int         pckg_sz   = 16,
   parameter int         depth     = 8,
   parameter logic [7:0] my_id     = 8'h00,
   parameter logic [7:0] broadcast = 8'hFF
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic                   pndng,
   input  logic                   pop,
   output logic [pckg_sz-1:0]     D_pop,
   input  logic                   push,
   input  logic [pckg_sz-1:0]     D_push,
   input  logic                   wr_en,
   input  logic [pckg_sz-1:0]     wr_data,
   output logic                   tx_full,
   input  logic                   rd_en,
   output logic [pckg_sz-1:0]     rd_data,
   output logic                   rx_empty,
   output logic [$clog2(depth):0] rx_cnt,
   output logic [7:0]             drop_cnt,
   output logic [2:0]             err
);

   logic                   tx_empty, rx_full;
   logic [$clog2(depth):0] tx_cnt_unused;
   id_t                    rx_id;
   logic                   id_match, rx_accept, rx_drop;
   logic [7:0]             drop_cnt_q, drop_cnt_d;
   logic [2:0]             err_q, err_d;

   assign rx_id     = pkt_id(PKT_MAX_W'(D_push), pckg_sz);
   assign id_match  = (rx_id == my_id) || (rx_id == broadcast);
   assign rx_accept = push && id_match;
   // A full RX queue still takes the packet when the device reads in the same cycle.
   assign rx_drop   = push && !(id_match && (!rx_full || rd_en));

   fifo_fwft #(.width(pckg_sz), .depth(depth)) u_tx (
      .clk   (clk),
      .reset (reset),
      .push  (wr_en),
      .pop   (pop),
      .din   (wr_data),
      .dout  (D_pop),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_cnt_unused)
   );

   fifo_fwft #(.width(pckg_sz), .depth(depth)) u_rx (
      .clk   (clk),
      .reset (reset),
      .push  (rx_accept),
      .pop   (rd_en),
      .din   (D_push),
      .dout  (rd_data),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_cnt)
   );

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      err_d      = err_q;
      if (rx_drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      if (wr_en && tx_full && !pop)       err_d[ERR_TX_OVF] = 1'b1;
      if (pop && tx_empty)                err_d[ERR_TX_UDF] = 1'b1;
      if (rd_en && rx_empty)              err_d[ERR_RX_UDF] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_cnt_q <= '0;
         err_q      <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
         err_q      <= err_d;
      end
   end

   assign pndng    = !tx_empty;
   assign drop_cnt = drop_cnt_q;
   assign err      = err_q;

endmodule

// File: tb/tb_bus_dev_port.sv
// Directed bench for bus_dev_port with a queue-based scoreboard of both FIFOs, drop count and error flags.
module tb_bus_dev_port;

   localparam int         DEPTH = 8;
   localparam logic [7:0] MY_ID = 8'h03;

   logic        clk = 1'b0;
   logic        reset;
   logic        pndng, pop, push, wr_en, rd_en, tx_full, rx_empty;
   logic [15:0] D_pop, D_push, wr_data, rd_data;
   logic [3:0]  rx_cnt;
   logic [7:0]  drop_cnt;
   logic [2:0]  err;

   logic [15:0] tx_q[$];
   logic [15:0] rx_q[$];
   logic [7:0]  drop_exp;
   logic [2:0]  err_exp;
   int          checks = 0;
   int          errors = 0;

   bus_dev_port #(.pckg_sz(16), .depth(DEPTH), .my_id(MY_ID), .broadcast(8'hFF)) dut (
      .clk      (clk),
      .reset    (reset),
      .pndng    (pndng),
      .pop      (pop),
      .D_pop    (D_pop),
      .push     (push),
      .D_push   (D_push),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .tx_full  (tx_full),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rx_empty (rx_empty),
      .rx_cnt   (rx_cnt),
      .drop_cnt (drop_cnt),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state();
      check("pndng",    32'(pndng),    32'(tx_q.size() != 0));
      check("tx_full",  32'(tx_full),  32'(tx_q.size() == DEPTH));
      check("rx_empty", 32'(rx_empty), 32'(rx_q.size() == 0));
      check("rx_cnt",   32'(rx_cnt),   32'(rx_q.size()));
      check("drop_cnt", 32'(drop_cnt), 32'(drop_exp));
      check("err",      32'(err),      32'(err_exp));
      if (tx_q.size() != 0) check("D_pop_head",   32'(D_pop),   32'(tx_q[0]));
      if (rx_q.size() != 0) check("rd_data_head", 32'(rd_data), 32'(rx_q[0]));
   endtask

   task automatic model_clear();
      tx_q.delete();
      rx_q.delete();
      drop_exp = '0;
      err_exp  = '0;
   endtask

   // One clock of stimulus: update the scoreboard, drive, clock, then compare everything.
   task automatic drive(input bit w, input logic [15:0] wd, input bit p, input bit r,
                        input bit u, input logic [15:0] pd);
      bit         tx_was_full, rx_was_full, tx_popped, rx_popped;
      logic [7:0] id;
      tx_was_full = (tx_q.size() == DEPTH);
      rx_was_full = (rx_q.size() == DEPTH);
      tx_popped   = 1'b0;
      rx_popped   = 1'b0;
      id          = pd[15:8];
      if (p) begin
         if (tx_q.size() != 0) begin
            check("pop_data", 32'(D_pop), 32'(tx_q[0]));
            void'(tx_q.pop_front());
            tx_popped = 1'b1;
         end else err_exp[1] = 1'b1;
      end
      if (w) begin
         if (!tx_was_full || tx_popped) tx_q.push_back(wd);
         else err_exp[0] = 1'b1;
      end
      if (r) begin
         if (rx_q.size() != 0) begin
            check("read_data", 32'(rd_data), 32'(rx_q[0]));
            void'(rx_q.pop_front());
            rx_popped = 1'b1;
         end else err_exp[2] = 1'b1;
      end
      if (u) begin
         if ((id == MY_ID || id == 8'hFF) && (!rx_was_full || rx_popped)) rx_q.push_back(pd);
         else if (drop_exp != 8'hFF) drop_exp = drop_exp + 8'd1;
      end
      wr_en = w; wr_data = wd; pop = p; rd_en = r; push = u; D_push = pd;
      @(posedge clk);
      #1;
      wr_en = 1'b0; pop = 1'b0; rd_en = 1'b0; push = 1'b0;
      check_state();
   endtask

   // Reset pulse placed between clock edges; outputs must clear before the next edge.
   task automatic mid_cycle_reset();
      @(posedge clk);
      #3 reset = 1'b1;
      model_clear();
      #1 check_state();
      check("pndng_async", 32'(pndng), 32'(0));
      #2 reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      pop = 1'b0; push = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      D_push = '0; wr_data = '0;
      model_clear();
      #12 reset = 1'b0;
      check_state();

      // TX basic: two writes, two pops
      drive(1, 16'h0233, 0, 0, 0, '0);
      drive(1, 16'hFF55, 0, 0, 0, '0);
      check("first_head", 32'(D_pop), 32'h0233);
      drive(0, '0, 1, 0, 0, '0);
      check("second_head", 32'(D_pop), 32'hFF55);
      drive(0, '0, 1, 0, 0, '0);
      check("tx_drained", 32'(pndng), 32'(0));

      // RX filtering
      drive(0, '0, 0, 0, 1, 16'h03AA);
      drive(0, '0, 0, 0, 1, 16'hFF01);
      drive(0, '0, 0, 0, 1, 16'h0477);
      check("rx_cnt_filtered", 32'(rx_cnt), 32'(2));
      check("drop_after_mismatch", 32'(drop_cnt), 32'(1));
      drive(0, '0, 0, 1, 0, '0);
      drive(0, '0, 0, 1, 0, '0);

      // RX full: overflow drop, then push with simultaneous read
      for (int i = 0; i < DEPTH; i++) drive(0, '0, 0, 0, 1, {MY_ID, 8'(i)});
      drive(0, '0, 0, 0, 1, 16'h03EE);
      drive(0, '0, 0, 1, 1, 16'h03DD);
      for (int i = 0; i < DEPTH; i++) drive(0, '0, 0, 1, 0, '0);

      // TX full: overflow write, then write with pop
      for (int i = 0; i < DEPTH; i++) drive(1, 16'h1000 + 16'(i), 0, 0, 0, '0);
      drive(1, 16'h1EEE, 0, 0, 0, '0);
      check("tx_ovf_flag", 32'(err[0]), 32'(1));
      drive(1, 16'h2000, 1, 0, 0, '0);
      check("tx_full_kept", 32'(tx_full), 32'(1));
      for (int i = 0; i < DEPTH; i++) drive(0, '0, 1, 0, 0, '0);

      // Underflow on both queues
      mid_cycle_reset();
      drive(0, '0, 1, 1, 0, '0);
      check("err_underflow", 32'(err), 32'b110);
      drive(1, 16'hABCD, 0, 0, 0, '0);
      drive(0, '0, 0, 1, 1, 16'h0310);
      check("rx_push_during_udf", 32'(rd_data), 32'h0310);
      drive(0, '0, 1, 1, 0, '0);

      // Pointer wrap
      for (int i = 0; i < 20; i++) begin
         drive(1, 16'($urandom), 0, 0, 0, '0);
         drive(0, '0, 1, 0, 0, '0);
      end

      // Drop counter saturation
      for (int i = 0; i < 300; i++) drive(0, '0, 0, 0, 1, {8'h05, 8'(i)});
      check("drop_saturated", 32'(drop_cnt), 32'hFF);

      // Reset with TX loaded
      for (int i = 0; i < 3; i++) drive(1, 16'h7700 + 16'(i), 0, 0, 0, '0);
      mid_cycle_reset();
      drive(1, 16'hBEEF, 0, 0, 0, '0);
      check("post_reset_head", 32'(D_pop), 32'hBEEF);
      drive(1, 16'hCAFE, 1, 0, 0, '0);
      drive(0, '0, 1, 0, 0, '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
